// File: rtl/os_frame_scheduler.sv
// Flow controller for the overlap-save sliding buffer: forwards accepted samples,
// freezes the buffer once a frame is complete, and hands the frame to the engine.
module os_frame_scheduler #(
  parameter int NB_DATA      = 16,
  parameter int N_DATA       = 32,
  parameter int N_OVERLAP    = 16,
  parameter int NB_FRAME_CNT = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic                    i_flush,
  input  logic [NB_DATA-1:0]      i_s_data,
  input  logic                    i_s_valid,
  output logic                    o_s_ready,
  output logic [NB_DATA-1:0]      o_buf_data,
  output logic                    o_buf_valid,
  output logic                    o_buf_rst,
  output logic                    o_start,
  input  logic                    i_done,
  output logic                    o_busy,
  output logic [NB_FRAME_CNT-1:0] o_frame_cnt
);

  localparam int NB_FILL = (N_DATA > 1) ? $clog2(N_DATA) : 1;
  localparam int NB_HOP  = (N_OVERLAP > 1) ? $clog2(N_OVERLAP) : 1;
  localparam logic [NB_FILL-1:0] FILL_LAST = NB_FILL'(N_DATA - 1);
  localparam logic [NB_HOP-1:0]  HOP_LAST  = NB_HOP'(N_OVERLAP - 1);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_STREAM,
    ST_START,
    ST_BUSY
  } state_t;

  state_t                  state_reg;
  logic [NB_FILL-1:0]      fill_cnt_reg;
  logic [NB_HOP-1:0]       hop_cnt_reg;
  logic                    start_reg;
  logic                    busy_reg;
  logic                    buf_rst_reg;
  logic [NB_FRAME_CNT-1:0] frame_cnt_reg;

  logic accepting_state;
  logic ready;
  logic accept;

  // Ready is also dropped in the reset, flush and buffer-reset cycles so that
  // no sample can slip into a buffer that is about to be cleared.
  assign accepting_state = (state_reg == ST_FILL) || (state_reg == ST_STREAM);
  assign ready           = i_enable & accepting_state & ~i_rst & ~i_flush & ~buf_rst_reg;
  assign accept          = i_s_valid & ready;

  assign o_s_ready   = ready;
  assign o_buf_valid = accept;
  assign o_buf_data  = i_s_data;
  assign o_buf_rst   = buf_rst_reg;
  assign o_start     = start_reg;
  assign o_busy      = busy_reg;
  assign o_frame_cnt = frame_cnt_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= ST_FILL;
      fill_cnt_reg  <= '0;
      hop_cnt_reg   <= '0;
      start_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      buf_rst_reg   <= 1'b0;
      frame_cnt_reg <= '0;
    end else if (i_flush) begin
      // Frame count survives a flush; everything else re-primes.
      state_reg    <= ST_FILL;
      fill_cnt_reg <= '0;
      hop_cnt_reg  <= '0;
      start_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      buf_rst_reg  <= 1'b1;
    end else begin
      buf_rst_reg <= 1'b0;
      start_reg   <= 1'b0;
      case (state_reg)
        ST_FILL: begin
          if (accept) begin
            if (fill_cnt_reg == FILL_LAST) begin
              state_reg     <= ST_START;
              hop_cnt_reg   <= '0;
              start_reg     <= 1'b1;
              frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end else begin
              fill_cnt_reg <= fill_cnt_reg + 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (accept) begin
            if (hop_cnt_reg == HOP_LAST) begin
              state_reg     <= ST_START;
              hop_cnt_reg   <= '0;
              start_reg     <= 1'b1;
              frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end else begin
              hop_cnt_reg <= hop_cnt_reg + 1'b1;
            end
          end
        end
        ST_START: begin
          // A done arriving together with start belongs to no frame yet.
          state_reg <= ST_BUSY;
          busy_reg  <= 1'b1;
        end
        ST_BUSY: begin
          if (i_done) begin
            state_reg <= ST_STREAM;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_FILL;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule
